// File: rtl/hwt_activation_monitor_if.sv
// Signal bundle between the hwt block, its supervisor and the monitor.
interface hwt_activation_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             Y;
  logic             ACK;
  logic             PULSE;
  logic [CNT_W-1:0] EVT_CNT;
  logic [3:0]       FIRST_VEC;
  logic             VEC_VALID;
  logic             ALARM;

  modport master (
    output A, B, C, D, Y, ACK,
    input  PULSE, EVT_CNT, FIRST_VEC,
    input  VEC_VALID, ALARM
  );

  modport slave (
    input  A, B, C, D, Y, ACK,
    output PULSE, EVT_CNT, FIRST_VEC,
    output VEC_VALID, ALARM
  );
endinterface

// File: rtl/hwt_activation_monitor.sv
// Counts rising edges of the hwt payload Y, latches the first trigger
// vector and raises a sticky alarm at a threshold until acknowledged.
module hwt_activation_monitor #(
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  hwt_activation_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTING,
    S_ALARM
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH =
    CNT_W'(ALARM_THRESH);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  state_e           state_q, state_d;
  logic             y_d_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       vec_q, vec_d;
  logic             vv_q, vv_d;
  logic             alarm_q;

  logic             act;
  logic             ack_ok;
  logic [CNT_W-1:0] cnt_base;
  logic             vv_base;

  // Acknowledge is resolved before the activation on the same edge.
  always_comb begin
    act      = bus.Y & ~y_d_q;
    ack_ok   = bus.ACK && (state_q == S_ALARM);
    cnt_base = ack_ok ? '0 : cnt_q;
    vv_base  = vv_q & ~ack_ok;
    cnt_d    = cnt_base;
    vec_d    = vec_q;
    vv_d     = vv_base;
    if (act) begin
      if (cnt_base != CNT_MAX)
        cnt_d = cnt_base + ONE;
      if (!vv_base) begin
        vec_d = {bus.A, bus.B, bus.C, bus.D};
        vv_d  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (act)
          state_d = (cnt_d >= TH) ? S_ALARM
                                  : S_COUNTING;
      end
      S_COUNTING: begin
        if (act && cnt_d >= TH)
          state_d = S_ALARM;
      end
      S_ALARM: begin
        if (ack_ok) begin
          if (!act)
            state_d = S_IDLE;
          else if (cnt_d >= TH)
            state_d = S_ALARM;
          else
            state_d = S_COUNTING;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      y_d_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      vec_q   <= 4'b0000;
      vv_q    <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_d_q   <= bus.Y;
      pulse_q <= act;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      vv_q    <= vv_d;
      alarm_q <= (state_d == S_ALARM);
    end
  end

  assign bus.PULSE     = pulse_q;
  assign bus.EVT_CNT   = cnt_q;
  assign bus.FIRST_VEC = vec_q;
  assign bus.VEC_VALID = vv_q;
  assign bus.ALARM     = alarm_q;

endmodule
